// File: rtl/ld_st_control_sequencer_if.sv
// Control bundle between the load/store sequencer and the datapath it drives.
interface ld_st_control_sequencer_if;
    logic [31:0] ir;
    logic        CONFFOut;
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [4:0]  Control_Signals;
    logic        MD_Read;
    logic        ReadRAM;
    logic        WriteRAM;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic        BAout;
    logic        run;

    modport master (
        input  ir, CONFFOut,
        output enable, busSelect, Control_Signals, MD_Read, ReadRAM, WriteRAM,
               Gra, Grb, Grc, Rin, Rout, BAout, run
    );

    modport slave (
        output ir, CONFFOut,
        input  enable, busSelect, Control_Signals, MD_Read, ReadRAM, WriteRAM,
               Gra, Grb, Grc, Rin, Rout, BAout, run
    );
endinterface

// File: rtl/ld_st_control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then per-opcode execute T3-T7.
// RAM-access states stretch by MEM_WAIT cycles using a 2-bit wait counter.
module ld_st_control_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic                          clk,
    input  logic                          clr,
    ld_st_control_sequencer_if.master     bus
);
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_T7    = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_BR   = 3'd4;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADDI = 5'b00011;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [1:0] WAIT_LAST = MEM_WAIT[1:0];

    logic [3:0]  r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_wait;
    logic [3:0]  w_next_state;
    logic [2:0]  w_next_op;
    logic        w_mem_state;
    logic        w_last;

    logic [31:0] w_enable;
    logic [31:0] w_bus_sel;
    logic [4:0]  w_ctrl;
    logic        w_md_read;
    logic        w_read_ram;
    logic        w_write_ram;
    logic        w_gra;
    logic        w_grb;
    logic        w_rin;
    logic        w_rout;
    logic        w_baout;
    logic        w_run;

    // Memory states are T1 always, T6 of ld and T7 of st.
    assign w_mem_state = (r_state == S_T1) ||
                         ((r_state == S_T6) && (r_op == OP_LD)) ||
                         ((r_state == S_T7) && (r_op == OP_ST));
    assign w_last      = !w_mem_state || (r_wait == WAIT_LAST);

    // Next-state and opcode-class selection.
    always_comb begin
        w_next_state = r_state;
        w_next_op    = r_op;
        case (r_state)
            S_RESET: w_next_state = S_T0;
            S_T0:    w_next_state = S_T1;
            S_T1: begin
                if (w_last) begin
                    w_next_state = S_T2;
                end else begin
                    w_next_state = S_T1;
                end
            end
            S_T2: begin
                case (bus.ir[31:27])
                    OPC_LD:   begin w_next_state = S_T3; w_next_op = OP_LD;   end
                    OPC_LDI:  begin w_next_state = S_T3; w_next_op = OP_LDI;  end
                    OPC_ST:   begin w_next_state = S_T3; w_next_op = OP_ST;   end
                    OPC_ADDI: begin w_next_state = S_T3; w_next_op = OP_ADDI; end
                    OPC_BR:   begin w_next_state = S_T3; w_next_op = OP_BR;   end
                    OPC_HALT: w_next_state = S_HALT;
                    default:  w_next_state = S_T0;
                endcase
            end
            S_T3: w_next_state = S_T4;
            S_T4: w_next_state = S_T5;
            S_T5: begin
                if ((r_op == OP_LDI) || (r_op == OP_ADDI)) begin
                    w_next_state = S_T0;
                end else begin
                    w_next_state = S_T6;
                end
            end
            S_T6: begin
                if (r_op == OP_BR) begin
                    w_next_state = S_T0;
                end else if (w_last) begin
                    w_next_state = S_T7;
                end else begin
                    w_next_state = S_T6;
                end
            end
            S_T7: begin
                if (w_last) begin
                    w_next_state = S_T0;
                end else begin
                    w_next_state = S_T7;
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_RESET;
        endcase
    end

    // State, opcode class and wait counter; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_RESET;
            r_op    <= OP_LD;
            r_wait  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_op    <= w_next_op;
            if (w_next_state != r_state) begin
                r_wait <= 2'd0;
            end else if (w_mem_state) begin
                r_wait <= r_wait + 2'd1;
            end else begin
                r_wait <= 2'd0;
            end
        end
    end

    // Moore output decode; only T1/T6 look at the wait count and br T6 at CONFFOut.
    always_comb begin
        w_enable    = 32'd0;
        w_bus_sel   = 32'd0;
        w_ctrl      = 5'd0;
        w_md_read   = 1'b0;
        w_read_ram  = 1'b0;
        w_write_ram = 1'b0;
        w_gra       = 1'b0;
        w_grb       = 1'b0;
        w_rin       = 1'b0;
        w_rout      = 1'b0;
        w_baout     = 1'b0;
        w_run       = 1'b1;
        case (r_state)
            S_T0: begin
                w_bus_sel[20] = 1'b1;
                w_enable[25]  = 1'b1;
                w_enable[18]  = 1'b1;
                w_ctrl        = 5'd14;
            end
            S_T1: begin
                w_bus_sel[19] = 1'b1;
                w_md_read     = 1'b1;
                w_read_ram    = 1'b1;
                w_enable[20]  = w_last;
                w_enable[21]  = w_last;
            end
            S_T2: begin
                w_bus_sel[21] = 1'b1;
                w_enable[24]  = 1'b1;
            end
            S_T3: begin
                if (r_op == OP_BR) begin
                    w_gra        = 1'b1;
                    w_rout       = 1'b1;
                    w_enable[26] = 1'b1;
                end else if (r_op == OP_ADDI) begin
                    w_grb        = 1'b1;
                    w_rout       = 1'b1;
                    w_enable[19] = 1'b1;
                end else begin
                    w_grb        = 1'b1;
                    w_baout      = 1'b1;
                    w_enable[19] = 1'b1;
                end
            end
            S_T4: begin
                if (r_op == OP_BR) begin
                    w_bus_sel[20] = 1'b1;
                    w_enable[19]  = 1'b1;
                end else begin
                    w_bus_sel[23] = 1'b1;
                    w_ctrl        = 5'd1;
                    w_enable[18]  = 1'b1;
                end
            end
            S_T5: begin
                case (r_op)
                    OP_BR: begin
                        w_bus_sel[23] = 1'b1;
                        w_ctrl        = 5'd1;
                        w_enable[18]  = 1'b1;
                    end
                    OP_LDI, OP_ADDI: begin
                        w_bus_sel[19] = 1'b1;
                        w_gra         = 1'b1;
                        w_rin         = 1'b1;
                    end
                    default: begin
                        w_bus_sel[19] = 1'b1;
                        w_enable[25]  = 1'b1;
                    end
                endcase
            end
            S_T6: begin
                case (r_op)
                    OP_BR: begin
                        w_bus_sel[19] = 1'b1;
                        w_enable[20]  = bus.CONFFOut;
                    end
                    OP_ST: begin
                        w_gra        = 1'b1;
                        w_rout       = 1'b1;
                        w_enable[21] = 1'b1;
                    end
                    default: begin
                        w_md_read    = 1'b1;
                        w_read_ram   = 1'b1;
                        w_enable[21] = w_last;
                    end
                endcase
            end
            S_T7: begin
                if (r_op == OP_ST) begin
                    w_write_ram = 1'b1;
                end else begin
                    w_bus_sel[21] = 1'b1;
                    w_gra         = 1'b1;
                    w_rin         = 1'b1;
                end
            end
            S_HALT:  w_run = 1'b0;
            default: w_run = 1'b1;
        endcase
    end

    assign bus.enable          = w_enable;
    assign bus.busSelect       = w_bus_sel;
    assign bus.Control_Signals = w_ctrl;
    assign bus.MD_Read         = w_md_read;
    assign bus.ReadRAM         = w_read_ram;
    assign bus.WriteRAM        = w_write_ram;
    assign bus.Gra             = w_gra;
    assign bus.Grb             = w_grb;
    assign bus.Grc             = 1'b0;
    assign bus.Rin             = w_rin;
    assign bus.Rout            = w_rout;
    assign bus.BAout           = w_baout;
    assign bus.run             = w_run;
endmodule
